// File: rtl/lift_pkg.sv
// Shared definitions for the lift controller front end.
//   NUM_BTN     : number of hall call buttons
//   BTN_*       : one-hot button codes (bit 0 = 1U ... bit 5 = 4D)
//   lift_dir_e  : LiftFSM output codes STAY/UP/DOWN
//   lowest_bit  : isolates the lowest-index set bit of a button vector
package lift_pkg;

  localparam int unsigned NUM_BTN = 6;

  localparam logic [NUM_BTN-1:0] BTN_1U = 6'b000001;
  localparam logic [NUM_BTN-1:0] BTN_2U = 6'b000010;
  localparam logic [NUM_BTN-1:0] BTN_3U = 6'b000100;
  localparam logic [NUM_BTN-1:0] BTN_2D = 6'b001000;
  localparam logic [NUM_BTN-1:0] BTN_3D = 6'b010000;
  localparam logic [NUM_BTN-1:0] BTN_4D = 6'b100000;

  typedef enum logic [1:0] {
    STAY = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } lift_dir_e;

  // Scans high to low so the lowest set bit is the last one written.
  function automatic logic [NUM_BTN-1:0] lowest_bit(input logic [NUM_BTN-1:0] v);
    logic [NUM_BTN-1:0] r;
    r = '0;
    for (int unsigned i = NUM_BTN; i > 0; i--) begin
      if (v[i-1]) begin
        r        = '0;
        r[i-1]   = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lift_request_queue_if.sv
// Request handshake between the request queue and LiftFSM.
//   button_out : one-hot head request (0 when empty)
//   qEmpty     : queue empty
//   done       : LiftFSM has completed the head request
// modport master = queue side, modport slave = LiftFSM side.
interface lift_request_queue_if;
  import lift_pkg::*;

  logic [NUM_BTN-1:0] button_out;
  logic               qEmpty;
  logic               done;

  modport master (output button_out, output qEmpty, input done);
  modport slave  (input button_out, input qEmpty, output done);
endinterface

// File: rtl/lift_request_queue_fifo.sv
// req_fifo: generic synchronous FIFO with synchronous active-high reset.
//   WIDTH, DEPTH : entry width / number of entries (DEPTH >= 2)
//   push, push_data : write an entry (ignored when full)
//   pop          : drop the head (ignored when empty)
//   head         : oldest entry, '0 when empty
//   empty, full, count : occupancy status
// Pointers wrap modulo DEPTH, so non-power-of-two depths are supported.
module req_fifo #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign head      = empty ? '0 : r_mem[r_rd];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= (r_wr == LAST) ? '0 : r_wr + 1'b1;
      if (w_do_pop)  r_rd <= (r_rd == LAST) ? '0 : r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/lift_request_queue.sv
// lift_request_queue: captures hall call presses, de-duplicates them and
// queues them in arrival order for LiftFSM.
//   clk, reset  : clock, synchronous active-high reset
//   button_raw  : synchronised panel levels (bit 0 = 1U ... bit 5 = 4D)
//   lift        : handshake to LiftFSM (button_out, qEmpty out; done in)
//   pending     : per-button lamp, on from latch until retired
//   full        : FIFO holds DEPTH entries
//   served_cnt  : retired-request counter, only with LIFT_REQ_CNT_EN defined
module lift_request_queue
  import lift_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BTN-1:0]     button_raw,
  lift_request_queue_if.master   lift,
  output logic [NUM_BTN-1:0]     pending,
  output logic                   full
`ifdef LIFT_REQ_CNT_EN
  ,
  output logic [7:0]             served_cnt
`endif
);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [NUM_BTN-1:0] r_btn_q;
  logic [NUM_BTN-1:0] r_wait;
  logic [NUM_BTN-1:0] r_queued;
  logic [NUM_BTN-1:0] w_edge;
  logic [NUM_BTN-1:0] w_pending;
  logic [NUM_BTN-1:0] w_sel;
  logic [NUM_BTN-1:0] w_head;
  logic [CW-1:0]      w_count;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;

  assign w_edge    = button_raw & ~r_btn_q;
  assign w_pending = r_wait | r_queued;
  assign w_sel     = lowest_bit(r_wait);
  // Full is taken before any same-cycle pop, so a freed slot is refilled next cycle.
  assign w_push    = (|r_wait) & ~w_full;
  assign w_pop     = lift.done & ~w_empty;

  req_fifo #(
    .WIDTH (NUM_BTN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_sel),
    .pop       (w_pop),
    .head      (w_head),
    .empty     (w_empty),
    .full      (w_full),
    .count     (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      // All ones so a button held through reset release produces no edge.
      r_btn_q  <= '1;
      r_wait   <= '0;
      r_queued <= '0;
    end else begin
      r_btn_q  <= button_raw;
      // A press on a button that is still pending (even if popped this cycle) is dropped.
      r_wait   <= (r_wait & ~(w_push ? w_sel : '0)) | (w_edge & ~w_pending);
      r_queued <= (r_queued & ~(w_pop ? w_head : '0)) | (w_push ? w_sel : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (w_full == (w_count == CW'(DEPTH)));
    end
  end

`ifdef LIFT_REQ_CNT_EN
  logic [7:0] r_served_cnt;
  always_ff @(posedge clk) begin
    if (reset)      r_served_cnt <= '0;
    else if (w_pop) r_served_cnt <= r_served_cnt + 8'd1;
  end
  assign served_cnt = r_served_cnt;
`endif

  assign lift.button_out = w_head;
  assign lift.qEmpty     = w_empty;
  assign pending         = w_pending;
  assign full            = w_full;
endmodule

// File: tb/tb_lift_request_queue.sv
// Directed bench for lift_request_queue (DEPTH=4). A per-cycle vector table
// covers single request, same-cycle presses, full/wait parking and spurious
// done; hand-written sequences cover de-dup, reset corners and push+pop.
module tb_lift_request_queue;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] button_raw;
  logic [5:0] pending;
  logic       full;
`ifdef LIFT_REQ_CNT_EN
  logic [7:0] served_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  lift_request_queue_if lif ();

  lift_request_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .button_raw (button_raw),
    .lift       (lif),
    .pending    (pending),
    .full       (full)
`ifdef LIFT_REQ_CNT_EN
    ,
    .served_cnt (served_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] raw;
    logic       done;
    logic [5:0] bo;
    logic       qe;
    logic [5:0] pend;
    logic       full;
  } vec_t;

  vec_t tv[33];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic cyc(input logic [5:0] r, input logic d);
    @(negedge clk);
    button_raw = r;
    lif.done   = d;
  endtask

  task automatic chk_out(input string tag, input logic [5:0] bo, input logic qe,
                         input logic [5:0] pend, input logic fl);
    chk({tag, ".button_out"}, {2'b00, lif.button_out}, {2'b00, bo});
    chk({tag, ".qEmpty"},     {7'd0, lif.qEmpty},      {7'd0, qe});
    chk({tag, ".pending"},    {2'b00, pending},        {2'b00, pend});
    chk({tag, ".full"},       {7'd0, full},            {7'd0, fl});
  endtask

  initial begin
    //           raw        done  button_out qE   pending    full
    // single request
    tv[0]  = '{6'b000000, 1'b0, 6'b000000, 1'b1, 6'b000000, 1'b0};
    tv[1]  = '{6'b000010, 1'b0, 6'b000000, 1'b1, 6'b000000, 1'b0};
    tv[2]  = '{6'b000000, 1'b0, 6'b000000, 1'b1, 6'b000010, 1'b0};
    tv[3]  = '{6'b000000, 1'b0, 6'b000010, 1'b0, 6'b000010, 1'b0};
    tv[4]  = '{6'b000000, 1'b1, 6'b000010, 1'b0, 6'b000010, 1'b0};
    tv[5]  = '{6'b000000, 1'b0, 6'b000000, 1'b1, 6'b000000, 1'b0};
    // same-cycle presses 1U + 4D
    tv[6]  = '{6'b100001, 1'b0, 6'b000000, 1'b1, 6'b000000, 1'b0};
    tv[7]  = '{6'b000000, 1'b0, 6'b000000, 1'b1, 6'b100001, 1'b0};
    tv[8]  = '{6'b000000, 1'b0, 6'b000001, 1'b0, 6'b100001, 1'b0};
    tv[9]  = '{6'b000000, 1'b1, 6'b000001, 1'b0, 6'b100001, 1'b0};
    tv[10] = '{6'b000000, 1'b0, 6'b100000, 1'b0, 6'b100000, 1'b0};
    tv[11] = '{6'b000000, 1'b1, 6'b100000, 1'b0, 6'b100000, 1'b0};
    tv[12] = '{6'b000000, 1'b0, 6'b000000, 1'b1, 6'b000000, 1'b0};
    // all six buttons in successive cycles, DEPTH=4
    tv[13] = '{6'b000001, 1'b0, 6'b000000, 1'b1, 6'b000000, 1'b0};
    tv[14] = '{6'b000010, 1'b0, 6'b000000, 1'b1, 6'b000001, 1'b0};
    tv[15] = '{6'b000100, 1'b0, 6'b000001, 1'b0, 6'b000011, 1'b0};
    tv[16] = '{6'b001000, 1'b0, 6'b000001, 1'b0, 6'b000111, 1'b0};
    tv[17] = '{6'b010000, 1'b0, 6'b000001, 1'b0, 6'b001111, 1'b0};
    tv[18] = '{6'b100000, 1'b0, 6'b000001, 1'b0, 6'b011111, 1'b1};
    tv[19] = '{6'b000000, 1'b0, 6'b000001, 1'b0, 6'b111111, 1'b1};
    tv[20] = '{6'b000000, 1'b1, 6'b000001, 1'b0, 6'b111111, 1'b1};
    tv[21] = '{6'b000000, 1'b0, 6'b000010, 1'b0, 6'b111110, 1'b0};
    tv[22] = '{6'b000000, 1'b0, 6'b000010, 1'b0, 6'b111110, 1'b1};
    tv[23] = '{6'b000000, 1'b1, 6'b000010, 1'b0, 6'b111110, 1'b1};
    tv[24] = '{6'b000000, 1'b0, 6'b000100, 1'b0, 6'b111100, 1'b0};
    tv[25] = '{6'b000000, 1'b1, 6'b000100, 1'b0, 6'b111100, 1'b1};
    tv[26] = '{6'b000000, 1'b1, 6'b001000, 1'b0, 6'b111000, 1'b0};
    tv[27] = '{6'b000000, 1'b0, 6'b010000, 1'b0, 6'b110000, 1'b0};
    tv[28] = '{6'b000000, 1'b1, 6'b010000, 1'b0, 6'b110000, 1'b0};
    tv[29] = '{6'b000000, 1'b1, 6'b100000, 1'b0, 6'b100000, 1'b0};
    tv[30] = '{6'b000000, 1'b0, 6'b000000, 1'b1, 6'b000000, 1'b0};
    // done while empty
    tv[31] = '{6'b000000, 1'b1, 6'b000000, 1'b1, 6'b000000, 1'b0};
    tv[32] = '{6'b000000, 1'b0, 6'b000000, 1'b1, 6'b000000, 1'b0};

    reset      = 1'b1;
    button_raw = '0;
    lif.done   = 1'b0;
    repeat (2) @(negedge clk);
    chk_out("reset", 6'b0, 1'b1, 6'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 33; i++) begin
      cyc(tv[i].raw, tv[i].done);
      chk_out($sformatf("vec%0d", i), tv[i].bo, tv[i].qe, tv[i].pend, tv[i].full);
    end
`ifdef LIFT_REQ_CNT_EN
    chk("served_cnt_table", served_cnt, 8'd9);
`endif

    // De-dup: 3U pressed three times, then once more in the cycle it is popped.
    cyc(6'b000100, 1'b0);
    cyc(6'b000000, 1'b0); chk("dedup.pend1", {2'b00, pending}, 8'b000100);
    cyc(6'b000000, 1'b0); chk("dedup.head", {2'b00, lif.button_out}, 8'b000100);
    cyc(6'b000100, 1'b0);
    cyc(6'b000000, 1'b0);
    cyc(6'b000000, 1'b0);
    cyc(6'b000100, 1'b0);
    cyc(6'b000000, 1'b0); chk("dedup.pend2", {2'b00, pending}, 8'b000100);
    chk("dedup.head2", {2'b00, lif.button_out}, 8'b000100);
    cyc(6'b000100, 1'b1);
    cyc(6'b000000, 1'b0);
    chk_out("dedup.after_pop", 6'b0, 1'b1, 6'b0, 1'b0);
    cyc(6'b000000, 1'b0);
    chk_out("dedup.after_pop2", 6'b0, 1'b1, 6'b0, 1'b0);

    // 2D held through reset release must not register.
    cyc(6'b001000, 1'b0); reset = 1'b1;
    cyc(6'b001000, 1'b0);
    cyc(6'b001000, 1'b0); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(6'b001000, 1'b0);
      chk_out($sformatf("held%0d", i), 6'b0, 1'b1, 6'b0, 1'b0);
    end
    cyc(6'b000000, 1'b0);

    // Reset with three entries queued discards everything.
    cyc(6'b000001, 1'b0);
    cyc(6'b000010, 1'b0);
    cyc(6'b000100, 1'b0);
    cyc(6'b000000, 1'b0);
    cyc(6'b000000, 1'b0);
    chk_out("q3", 6'b000001, 1'b0, 6'b000111, 1'b0);
    cyc(6'b000000, 1'b0); reset = 1'b1;
    cyc(6'b000000, 1'b0); reset = 1'b0;
    chk_out("midreset", 6'b0, 1'b1, 6'b0, 1'b0);
    cyc(6'b000000, 1'b0);
    chk_out("midreset2", 6'b0, 1'b1, 6'b0, 1'b0);

    // Push and pop in the same cycle at count 2: occupancy stays 2.
    cyc(6'b000001, 1'b0);
    cyc(6'b000010, 1'b0);
    cyc(6'b000000, 1'b0);
    cyc(6'b000100, 1'b0);
    chk_out("pp.pre", 6'b000001, 1'b0, 6'b000011, 1'b0);
    cyc(6'b000000, 1'b1);
    chk("pp.pend_wait", {2'b00, pending}, 8'b000111);
    cyc(6'b000000, 1'b1);
    chk_out("pp.pop1", 6'b000010, 1'b0, 6'b000110, 1'b0);
    cyc(6'b000000, 1'b1);
    chk_out("pp.pop2", 6'b000100, 1'b0, 6'b000100, 1'b0);
    cyc(6'b000000, 1'b0);
    chk_out("pp.empty", 6'b0, 1'b1, 6'b0, 1'b0);
`ifdef LIFT_REQ_CNT_EN
    chk("served_cnt_end", served_cnt, 8'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
